// File: rtl/reg_file_pkg.sv
// Shared helpers for the 2-read/1-write register file: byte-enable mask
// expansion and address range checking.
package reg_file_pkg;

  // Upper bound on supported data width; callers size-cast the results down.
  localparam int unsigned MAX_WIDTH = 1024;
  localparam int unsigned MAX_BYTES = MAX_WIDTH / 8;

  // Expand one enable bit per byte into a full bit mask.
  function automatic logic [MAX_WIDTH-1:0] be_to_mask(input logic [MAX_BYTES-1:0] be);
    logic [MAX_WIDTH-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      mask[i*8 +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

  // True when an address maps onto a physical entry.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: entry select, same-cycle write bypass,
// zero-register and out-of-range masking, output registers.
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [DEPTH-1:0][WIDTH-1:0]  i_mem,
  input  logic                         i_wr_ok,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic [WIDTH-1:0]             i_wr_data,
  input  logic [WIDTH-1:0]             i_wr_mask,
  input  logic                         i_rd_en,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  output logic [WIDTH-1:0]             o_rd_data,
  output logic                         o_rd_valid,
  output logic                         o_addr_oor
);

  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_rd_val;
  logic             w_in_range;
  logic             w_hit;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  // Select the addressed entry, merge an in-flight write, then force zero
  // for out-of-range addresses and the hardwired zero entry.
  always_comb begin
    w_in_range = addr_in_range(32'(i_rd_addr), DEPTH);
    w_old      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ADDR_W'(i) == i_rd_addr) w_old = i_mem[i];
    end
    w_hit    = (BYPASS != 0) && i_wr_ok && (i_wr_addr == i_rd_addr);
    w_rd_val = w_hit ? ((w_old & ~i_wr_mask) | (i_wr_data & i_wr_mask)) : w_old;
    if (!w_in_range || ((ZERO_REG != 0) && (i_rd_addr == '0))) w_rd_val = '0;
  end

  assign o_addr_oor = i_rd_en && !w_in_range;

  // Output registers: valid pulses per request, data holds when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) r_rd_data <= w_rd_val;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised register file: one byte-enabled write port, two independent
// registered read ports, optional write bypass and hardwired zero entry.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic                 rd0_en,
  input  logic [ADDR_W-1:0]    rd0_addr,
  output logic [WIDTH-1:0]     rd0_data,
  output logic                 rd0_valid,
  input  logic                 rd1_en,
  input  logic [ADDR_W-1:0]    rd1_addr,
  output logic [WIDTH-1:0]     rd1_data,
  output logic                 rd1_valid,
  output logic                 addr_err
);

  if ((WIDTH % 8) != 0) begin : g_chk_width
    $error("reg_file_2r1w: WIDTH must be a multiple of 8");
  end
  if ((DEPTH < 2) || (DEPTH > (1 << ADDR_W))) begin : g_chk_depth
    $error("reg_file_2r1w: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_W");
  end

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [WIDTH-1:0]            w_mask;
  logic                        w_wr_in_range;
  logic                        w_wr_ok;
  logic                        w_rd0_oor;
  logic                        w_rd1_oor;
  logic                        r_addr_err;

  assign w_mask        = WIDTH'(be_to_mask(MAX_BYTES'(wr_be)));
  assign w_wr_in_range = addr_in_range(32'(wr_addr), DEPTH);
  assign w_wr_ok       = wr_en && w_wr_in_range && !((ZERO_REG != 0) && (wr_addr == '0));

  // Storage: byte-merged update of the addressed entry only.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_mem <= '0;
    end else if (w_wr_ok) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ADDR_W'(i) == wr_addr) r_mem[i] <= (r_mem[i] & ~w_mask) | (wr_data & w_mask);
      end
    end
  end

  rf_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_rd0 (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_mem      (r_mem),
    .i_wr_ok    (w_wr_ok),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_wr_mask  (w_mask),
    .i_rd_en    (rd0_en),
    .i_rd_addr  (rd0_addr),
    .o_rd_data  (rd0_data),
    .o_rd_valid (rd0_valid),
    .o_addr_oor (w_rd0_oor)
  );

  rf_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_rd1 (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_mem      (r_mem),
    .i_wr_ok    (w_wr_ok),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_wr_mask  (w_mask),
    .i_rd_en    (rd1_en),
    .i_rd_addr  (rd1_addr),
    .o_rd_data  (rd1_data),
    .o_rd_valid (rd1_valid),
    .o_addr_oor (w_rd1_oor)
  );

  // Flag any enabled access that missed the physical entries last cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_addr_err <= 1'b0;
    else      r_addr_err <= (wr_en && !w_wr_in_range) || w_rd0_oor || w_rd1_oor;
  end

  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench driving three builds in lockstep:
//   dut0: DEPTH=8 BYPASS=1 ZERO_REG=0
//   dut1: DEPTH=8 BYPASS=0 ZERO_REG=0
//   dut2: DEPTH=6 BYPASS=1 ZERO_REG=1
module tb_reg_file_2r1w;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic        rd0_en = 1'b0;
  logic [2:0]  rd0_addr = '0;
  logic        rd1_en = 1'b0;
  logic [2:0]  rd1_addr = '0;

  logic [15:0] d0_a, d0_b, d0_c, d1_a, d1_b, d1_c;
  logic        v0_a, v0_b, v0_c, v1_a, v1_b, v1_c;
  logic        ae_a, ae_b, ae_c;

  logic [2:0][15:0] d0, d1;
  logic [2:0]       v0, v1, ae;
  assign d0 = {d0_c, d0_b, d0_a};
  assign d1 = {d1_c, d1_b, d1_a};
  assign v0 = {v0_c, v0_b, v0_a};
  assign v1 = {v1_c, v1_b, v1_a};
  assign ae = {ae_c, ae_b, ae_a};

  always #5 CLK = ~CLK;

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) u_a (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(d0_a), .rd0_valid(v0_a),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(d1_a), .rd1_valid(v1_a), .addr_err(ae_a));

  reg_file_2r1w #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) u_b (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(d0_b), .rd0_valid(v0_b),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(d1_b), .rd1_valid(v1_b), .addr_err(ae_b));

  reg_file_2r1w #(.WIDTH(16), .DEPTH(6), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) u_c (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(d0_c), .rd0_valid(v0_c),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(d1_c), .rd1_valid(v1_c), .addr_err(ae_c));

  typedef struct packed {
    logic             v0;
    logic             v1;
    logic [2:0][15:0] e0;
    logic [2:0][15:0] e1;
    logic [2:0]       er;
  } exp_t;

  exp_t sq[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry per issued cycle, compared on the falling edge.
  always @(negedge CLK) begin
    if (RST) begin
      if (sq.size() != 0) begin
        mon_e = sq.pop_front();
        for (int d = 0; d < 3; d++) begin
          check("rd0_valid", d, 16'(v0[d]), 16'(mon_e.v0));
          check("rd1_valid", d, 16'(v1[d]), 16'(mon_e.v1));
          if (mon_e.v0) check("rd0_data", d, d0[d], mon_e.e0[d]);
          if (mon_e.v1) check("rd1_data", d, d1[d], mon_e.e1[d]);
          check("addr_err", d, 16'(ae[d]), 16'(mon_e.er[d]));
        end
      end else begin
        for (int d = 0; d < 3; d++) begin
          check("rd0_valid_idle", d, 16'(v0[d]), 16'h0);
          check("rd1_valid_idle", d, 16'(v1[d]), 16'h0);
        end
      end
    end
  end

  // Issue one cycle of stimulus; expected data order is dut0, dut1, dut2,
  // expected addr_err bits are {dut2, dut1, dut0}.
  task automatic step(
    input logic we, input logic [2:0] wa, input logic [15:0] wd, input logic [1:0] be,
    input logic r0e, input logic [2:0] r0a, input logic r1e, input logic [2:0] r1a,
    input logic [15:0] e0a, input logic [15:0] e0b, input logic [15:0] e0c,
    input logic [15:0] e1a, input logic [15:0] e1b, input logic [15:0] e1c,
    input logic [2:0] er);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd0_en = r0e; rd0_addr = r0a; rd1_en = r1e; rd1_addr = r1a;
    e.v0 = r0e; e.v1 = r1e;
    e.e0 = {e0c, e0b, e0a};
    e.e1 = {e1c, e1b, e1a};
    e.er = er;
    sq.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_be = '0; rd0_en = 1'b0; rd1_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_rd0_data", d, d0[d], 16'h0);
      check("rst_rd1_data", d, d1[d], 16'h0);
      check("rst_rd0_valid", d, 16'(v0[d]), 16'h0);
      check("rst_rd1_valid", d, 16'(v1[d]), 16'h0);
      check("rst_addr_err", d, 16'(ae[d]), 16'h0);
    end
    RST = 1'b1;

    //   we wa    wd        be     r0e r0a   r1e r1a    e0 (d0,d1,d2)              e1 (d0,d1,d2)              er
    step(0, 3'd0, 16'h0000, 2'b00, 1, 3'd3, 1, 3'd3, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000, 3'b000);
    step(1, 3'd2, 16'hAABB, 2'b11, 0, 3'd0, 0, 3'd0, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000, 3'b000);
    step(1, 3'd2, 16'h1234, 2'b01, 0, 3'd0, 0, 3'd0, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000, 3'b000);
    step(0, 3'd0, 16'h0000, 2'b00, 1, 3'd2, 1, 3'd2, 16'hAA34,16'hAA34,16'hAA34, 16'hAA34,16'hAA34,16'hAA34, 3'b000);
    step(1, 3'd5, 16'hBEEF, 2'b11, 0, 3'd0, 0, 3'd0, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000, 3'b000);
    step(1, 3'd6, 16'h1111, 2'b11, 0, 3'd0, 0, 3'd0, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000, 3'b100);
    step(0, 3'd0, 16'h0000, 2'b00, 1, 3'd5, 1, 3'd6, 16'hBEEF,16'hBEEF,16'hBEEF, 16'h1111,16'h1111,16'h0000, 3'b100);
    step(0, 3'd0, 16'h0000, 2'b00, 0, 3'd0, 0, 3'd0, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000, 3'b000);
    step(1, 3'd4, 16'h00FF, 2'b11, 0, 3'd0, 0, 3'd0, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000, 3'b000);
    step(1, 3'd4, 16'hFF00, 2'b10, 1, 3'd4, 0, 3'd0, 16'hFFFF,16'h00FF,16'hFFFF, 16'h0000,16'h0000,16'h0000, 3'b000);
    step(0, 3'd0, 16'h0000, 2'b00, 1, 3'd4, 1, 3'd0, 16'hFFFF,16'hFFFF,16'hFFFF, 16'h0000,16'h0000,16'h0000, 3'b000);
    step(1, 3'd0, 16'h5555, 2'b11, 0, 3'd0, 0, 3'd0, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000, 3'b000);
    step(0, 3'd0, 16'h0000, 2'b00, 1, 3'd0, 1, 3'd7, 16'h5555,16'h5555,16'h0000, 16'h0000,16'h0000,16'h0000, 3'b100);
    step(1, 3'd0, 16'hA5A5, 2'b01, 0, 3'd0, 1, 3'd0, 16'h0000,16'h0000,16'h0000, 16'h55A5,16'h5555,16'h0000, 3'b000);
    step(1, 3'd7, 16'h7777, 2'b11, 1, 3'd0, 0, 3'd0, 16'h55A5,16'h55A5,16'h0000, 16'h0000,16'h0000,16'h0000, 3'b100);
    step(0, 3'd0, 16'h0000, 2'b00, 1, 3'd7, 1, 3'd5, 16'h7777,16'h7777,16'h0000, 16'hBEEF,16'hBEEF,16'hBEEF, 3'b100);
    step(1, 3'd5, 16'hFFFF, 2'b00, 1, 3'd5, 0, 3'd0, 16'hBEEF,16'hBEEF,16'hBEEF, 16'h0000,16'h0000,16'h0000, 3'b000);
    step(0, 3'd0, 16'h0000, 2'b00, 1, 3'd5, 1, 3'd2, 16'hBEEF,16'hBEEF,16'hBEEF, 16'hAA34,16'hAA34,16'hAA34, 3'b000);
    step(0, 3'd0, 16'h0000, 2'b00, 1, 3'd5, 0, 3'd0, 16'hBEEF,16'hBEEF,16'hBEEF, 16'h0000,16'h0000,16'h0000, 3'b000);

    // Asynchronous reset between edges while rd0_valid is high.
    idle_inputs();
    for (int d = 0; d < 3; d++) check("pre_rst_rd0_valid", d, 16'(v0[d]), 16'h1);
    RST = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check("async_rd0_valid", d, 16'(v0[d]), 16'h0);
      check("async_rd0_data", d, d0[d], 16'h0);
      check("async_rd1_data", d, d1[d], 16'h0);
      check("async_addr_err", d, 16'(ae[d]), 16'h0);
    end
    @(posedge CLK);
    @(negedge CLK);
    #1;
    RST = 1'b1;

    step(0, 3'd0, 16'h0000, 2'b00, 1, 3'd5, 1, 3'd2, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000, 3'b000);
    step(0, 3'd0, 16'h0000, 2'b00, 1, 3'd4, 1, 3'd6, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000, 3'b100);
    step(0, 3'd0, 16'h0000, 2'b00, 1, 3'd7, 1, 3'd0, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000, 3'b100);
    step(0, 3'd0, 16'h0000, 2'b00, 0, 3'd0, 0, 3'd0, 16'h0000,16'h0000,16'h0000, 16'h0000,16'h0000,16'h0000, 3'b000);

    repeat (2) @(negedge CLK);
    #1;
    n_chk++;
    if (sq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sq.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
Parametrised register file with one write port and two independent read ports. Supports byte-enable writes, registered reads with valid strobes, and optional same-cycle write-to-read bypass. Intended as the general-purpose storage element for datapath blocks needing concurrent operand reads, superseding the single-port register file.

Parameters:
WIDTH, 16, data width in bits; must be a multiple of 8
DEPTH, 8, number of entries; 2 <= DEPTH <= 2**ADDR_W
ADDR_W, 3, address width in bits
BYPASS, 1, 1 = a read of the address being written in the same cycle returns the new data; 0 = returns the old data
ZERO_REG, 0, 1 = entry 0 is hardwired to zero (reads return 0, writes are ignored)

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  asynchronous, active-low reset
wr_en  input  1  write request
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data
wr_be  input  WIDTH/8  byte enables; bit i gates wr_data[8i+7:8i]
rd0_en  input  1  read port 0 request
rd0_addr  input  ADDR_W  read port 0 address
rd0_data  output  WIDTH  read port 0 data (registered)
rd0_valid  output  1  read port 0 data valid, one-cycle pulse
rd1_en  input  1  read port 1 request
rd1_addr  input  ADDR_W  read port 1 address
rd1_data  output  WIDTH  read port 1 data (registered)
rd1_valid  output  1  read port 1 data valid, one-cycle pulse
addr_err  output  1  registered flag: an enabled access hit an address >= DEPTH in the previous cycle

Behaviour:
- Reset (RST=0, asynchronous): all entries = 0; rd0_data = rd1_data = 0; rd0_valid = rd1_valid = 0; addr_err = 0. Reset held across a clock edge blocks every write and read.
- Write: on a rising edge with wr_en=1 and wr_addr < DEPTH, bytes with wr_be[i]=1 are updated; the other bytes are preserved. wr_be=0 means no change (not an error).
- Read: on a rising edge with rdN_en=1, rdN_data <= entry[rdN_addr] and rdN_valid <= 1. Latency is 1 cycle. With rdN_en=0, rdN_valid <= 0 and rdN_data holds its previous value.
- The two read ports are fully independent; both may read the same address in the same cycle.
- Simultaneous write and read to the same address:
  - BYPASS=1: read returns the byte-merged result (new bytes where wr_be=1, old bytes elsewhere).
  - BYPASS=0: read returns the pre-write contents.
  - The write always completes in both modes.
- Simultaneous write and read to different addresses: both proceed with no interaction.
- ZERO_REG=1: writes to address 0 are dropped; reads of address 0 return 0, bypass included.
- Out-of-range (address >= DEPTH):
  - Write is ignored.
  - Read returns 0 with valid=1.
  - addr_err <= 1 for one cycle if any enabled port is out of range; otherwise addr_err <= 0.
  - This cannot occur when DEPTH = 2**ADDR_W; addr_err stays 0.
- No state machine. Storage is a flop array; the read path is a registered mux plus bypass merge.

Decomposition:
- Shared package reg_file_pkg: a function for byte-mask expansion (wr_be to a WIDTH-bit mask) and a function for the in-range check.
- Parameter legality checks (WIDTH%8==0, DEPTH <= 2**ADDR_W) live in the module as elaboration-time asserts.
- Sub-module rf_read_port, instantiated twice: address decode, bypass merge, zero-reg and range handling, output registers.

Test Plan:
- Reset then read: assert RST=0, release; read addr 3 on both ports -> next cycle rd0_data = rd1_data = 0x0000, both valid = 1.
- Byte-enable write: write 0xAABB to addr 2 with be=11; then write 0x1234 with be=01; read addr 2 -> 0xAA34.
- Dual read, same cycle: write 0xBEEF to addr 5 and 0x1111 to addr 6; read port 0 at addr 5 and port 1 at addr 6 in one cycle -> 0xBEEF / 0x1111 one cycle later, both valid pulse for one cycle.
- Collision: addr 4 holds 0x00FF; write 0xFF00 with be=10 while port 0 reads addr 4 -> BYPASS=1 returns 0xFFFF, BYPASS=0 returns 0x00FF; a follow-up read returns 0xFFFF in both builds.
- Zero register and range (ZERO_REG=1, DEPTH=6): write 0x5555 to addr 0, read -> 0x0000; write 0x7777 to addr 7 -> addr_err = 1 next cycle, no entry changes; read addr 7 -> 0x0000, valid = 1, addr_err = 1.
- Mid-operation reset: assert RST=0 asynchronously between edges while rd0_valid = 1 -> rd0_valid and rd0_data go to 0 immediately; all entries read 0 after release.
